// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Parity-mode constants, FSM state type and the parity-bit helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  // x is the XOR of the payload bits.
  function automatic logic par_bit(
    input logic x,
    input int   mode
  );
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Pushes are refused when full, regardless of a same-cycle pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push)
            - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign level = cnt_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed frame FSM.
// tx is registered from the current state, so it trails the FSM by one clock.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = $clog2(OVERSAMPLE);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic [DATA_BITS-1:0] rdata;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 load;
  logic                 bit_end;
  logic                 unused_hi;

  assign unused_hi = |(in_data >> DATA_BITS);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data[DATA_BITS-1:0]),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    load    = 1'b0;
    tx_done = 1'b0;
    bit_end = (cnt_q == CW'(OVERSAMPLE-1));
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'(DATA_BITS-1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE)
                    ? PAR : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS-1)) begin
            tx_done = 1'b1;
            if (!empty) load = 1'b1;
            else state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Next frame starts straight from IDLE or the last stop clock.
    if (load) begin
      pop     = 1'b1;
      sh_d    = rdata;
      par_d   = par_bit(^rdata, PARITY);
      state_d = START;
      bit_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[0];
      PAR:     tx_d = par_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign in_ready = !full;
  assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-002 Parameter OVERSAMPLE, default 16, meaning clocks per bit period; legal range 4..255.
REQ-003 Parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of 2, at least 2.
REQ-006 Port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-008 Port in_data, input, 8 bits, meaning word to send; bits [7:DATA_BITS] are ignored.
REQ-009 Port in_valid, input, 1 bit, meaning in_data is offered.
REQ-010 Port in_ready, output, 1 bit, meaning the FIFO can accept a word; equals not full.
REQ-011 Port tx, output, 1 bit, meaning serial line; registered; idle high.
REQ-012 Port busy, output, 1 bit, meaning the FSM is not IDLE or the FIFO is not empty.
REQ-013 Port tx_done, output, 1 bit, meaning a one-cycle pulse on the last clock of each frame's final stop bit.
REQ-014 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, meaning occupied FIFO entries.

Function
REQ-015 A word SHALL be accepted on any rising edge with in_valid and in_ready both high; no edge detection on in_valid.
REQ-016 A push SHALL be refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 There SHALL be no FIFO bypass; every word is written to, then read from, the FIFO.
REQ-018 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one word, load the shift register, and enter START.
REQ-020 Each state SHALL hold tx constant for exactly OVERSAMPLE clocks per bit, using a bit-period counter of width $clog2(OVERSAMPLE).
REQ-021 tx SHALL be 0 in START.
REQ-022 In DATA, tx SHALL carry the data bits LSB first, DATA_BITS of them.
REQ-023 In PAR, tx SHALL carry the parity bit: XOR of the DATA_BITS payload bits for even parity, its complement for odd parity.
REQ-024 PAR SHALL be skipped when PARITY is 0.
REQ-025 In STOP, tx SHALL be 1 for STOP_BITS bit periods.
REQ-026 Frame length SHALL be exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE clocks.
REQ-027 First-word latency: with the FSM in IDLE and the FIFO empty, a word accepted at edge k SHALL drive tx low from edge k+2.
REQ-028 Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next START bit SHALL begin on the very next clock, with no idle gap.
REQ-029 Upon leaving STOP, tx_done SHALL pulse in the same cycle that the pop for the next frame (if any) occurs.
REQ-030 Changes to in_data or in_valid during a frame SHALL NOT affect the frame in flight.

Reset
REQ-031 While rst is high: tx = 1, busy = 0, tx_done = 0, fifo_level = 0, in_ready = 1, FSM = IDLE, counters = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately (tx high asynchronously) and flush the FIFO.
REQ-033 After rst deasserts, the first accepted word SHALL follow REQ-027.

Structure
REQ-034 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state typedef.
REQ-035 The FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH, DEPTH) exposing push, pop, full, empty and level.
REQ-036 The FSM, counters, shift register and parity logic SHALL live in uart_tx_cfg.

Verification
REQ-037 Defaults (8N1, OVERSAMPLE 16), push 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clocks; frame 160 clocks; tx_done pulses once.
REQ-038 PARITY = 2, push 0xA5 -> parity bit 0; PARITY = 1 -> parity bit 1; frame 176 clocks.
REQ-039 DATA_BITS = 7, STOP_BITS = 2, push 0xFF -> seven 1 data bits, no eighth bit, 2 stop periods; frame 160 clocks.
REQ-040 Hold in_valid high with 6 words while tx is busy -> in_ready drops at fifo_level 4; all 6 words sent in order with zero idle gap between frames; busy falls after the last tx_done.
REQ-041 Assert rst at clock 50 of a frame with 2 words queued -> tx = 1 immediately, fifo_level = 0; no further frames after release.
REQ-042 Toggle in_data during a frame -> transmitted bits match the value latched at pop.
